// File: rtl/sdio_host_cmd.sv
`default_nettype none
// ============================================================================
// Module      : sdio_host_cmd
// Description : Host side of the SD/SDIO CMD line. Generates sd_clock,
//               serialises 48-bit commands (with serial CRC7) and receives
//               48-bit short responses with timeout and CRC/framing checks.
//               Optional macro SDIO_HOST_CMD_R4_EN adds the resp_no_crc input
//               that skips the CRC7 check for R4-style responses.
// Revision    : 1.0 - initial release
// ============================================================================
module sdio_host_cmd #(
    parameter int CLOCK_DIV = 100,
    parameter int NCR_MAX   = 64,
    parameter int NCC_CLKS  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_expected,
`ifdef SDIO_HOST_CMD_R4_EN
    input  logic        resp_no_crc,
`endif
    output logic        busy,
    output logic        done,
    output logic        resp_valid,
    output logic        resp_timeout,
    output logic        resp_crc_error,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        sd_clock,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_in
);

    localparam int DIV_W   = (CLOCK_DIV > 2) ? $clog2(CLOCK_DIV) : 1;
    localparam int CNT_MAX = (NCR_MAX > NCC_CLKS) ? NCR_MAX : NCC_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLOCK_DIV - 1);
    localparam logic [CNT_W-1:0] C_NCR_LAST = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] C_NCC_LAST = CNT_W'(NCC_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EDGE = 3'd1,
        SEND      = 3'd2,
        NCR       = 3'd3,
        RECV      = 3'd4,
        NCC       = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [39:0]        r_tx_shift;
    logic [45:0]        r_rx_shift;
    logic [6:0]         r_crc;
    logic [5:0]         r_bit_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_resp_exp;
    logic               w_no_crc;
    logic               w_wrap;
    logic               w_fall_tick;
    logic               w_rise_tick;
    logic [46:0]        w_rx_bits;
    logic               w_rx_good;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

`ifdef SDIO_HOST_CMD_R4_EN
    logic r_no_crc;

    // Latch the CRC-skip request with the rest of the command parameters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_no_crc <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_no_crc <= resp_no_crc;
        end
    end

    assign w_no_crc = r_no_crc;
`else
    assign w_no_crc = 1'b0;
`endif

    assign w_wrap      = (r_div_cnt == C_DIV_LAST);
    assign w_fall_tick = w_wrap & sd_clock;
    assign w_rise_tick = w_wrap & ~sd_clock;

    // Bits 46..0 of the response; the start bit is implied by entering RECV
    assign w_rx_bits = {r_rx_shift, sd_cmd_in};
    assign w_rx_good = ~w_rx_bits[46] & w_rx_bits[0] & (w_no_crc | (w_rx_bits[7:1] == r_crc));

    // Free-running sd_clock divider
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            sd_clock  <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            sd_clock  <= ~sd_clock;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and busy indication
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE:      if (start) w_state_next = WAIT_EDGE;
            WAIT_EDGE: if (w_fall_tick) w_state_next = SEND;
            SEND: begin
                if (w_fall_tick && r_bit_cnt == 6'd0) begin
                    w_state_next = r_resp_exp ? NCR : NCC;
                end
            end
            NCR: begin
                if (w_rise_tick) begin
                    if (!sd_cmd_in) begin
                        w_state_next = RECV;
                    end else if (r_cnt == C_NCR_LAST) begin
                        w_state_next = NCC;
                    end
                end
            end
            RECV:      if (w_rise_tick && r_bit_cnt == 6'd0) w_state_next = NCC;
            NCC:       if (w_rise_tick && r_cnt == C_NCC_LAST) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // Datapath: frame shifting, CRC, response capture, counters and flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_shift     <= '0;
            r_rx_shift     <= '0;
            r_crc          <= '0;
            r_bit_cnt      <= '0;
            r_cnt          <= '0;
            r_resp_exp     <= 1'b0;
            done           <= 1'b0;
            resp_valid     <= 1'b0;
            resp_timeout   <= 1'b0;
            resp_crc_error <= 1'b0;
            resp_index     <= '0;
            resp_arg       <= '0;
            sd_cmd_out     <= 1'b1;
            sd_cmd_oe      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tx_shift     <= {2'b01, cmd_index, cmd_arg};
                        r_resp_exp     <= resp_expected;
                        r_crc          <= '0;
                        resp_valid     <= 1'b0;
                        resp_timeout   <= 1'b0;
                        resp_crc_error <= 1'b0;
                    end
                end
                WAIT_EDGE: begin
                    if (w_fall_tick) begin
                        sd_cmd_oe  <= 1'b1;
                        sd_cmd_out <= r_tx_shift[39];
                        r_crc      <= crc7_step(r_crc, r_tx_shift[39]);
                        r_tx_shift <= {r_tx_shift[38:0], 1'b0};
                        r_bit_cnt  <= 6'd47;
                    end
                end
                SEND: begin
                    if (w_fall_tick) begin
                        if (r_bit_cnt == 6'd0) begin
                            sd_cmd_oe  <= 1'b0;
                            sd_cmd_out <= 1'b1;
                            r_crc      <= '0;
                            r_cnt      <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            if (r_bit_cnt > 6'd8) begin
                                sd_cmd_out <= r_tx_shift[39];
                                r_crc      <= crc7_step(r_crc, r_tx_shift[39]);
                                r_tx_shift <= {r_tx_shift[38:0], 1'b0};
                            end else if (r_bit_cnt > 6'd1) begin
                                sd_cmd_out <= r_crc[6];
                                r_crc      <= {r_crc[5:0], 1'b0};
                            end else begin
                                sd_cmd_out <= 1'b1;
                            end
                        end
                    end
                end
                NCR: begin
                    if (w_rise_tick) begin
                        if (!sd_cmd_in) begin
                            r_rx_shift <= '0;
                            r_crc      <= crc7_step(r_crc, 1'b0);
                            r_bit_cnt  <= 6'd46;
                        end else if (r_cnt == C_NCR_LAST) begin
                            resp_timeout <= 1'b1;
                            r_cnt        <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (w_rise_tick) begin
                        r_rx_shift <= w_rx_bits[45:0];
                        if (r_bit_cnt >= 6'd8) begin
                            r_crc <= crc7_step(r_crc, sd_cmd_in);
                        end
                        if (r_bit_cnt == 6'd0) begin
                            resp_valid     <= w_rx_good;
                            resp_crc_error <= ~w_rx_good;
                            resp_index     <= w_rx_bits[45:40];
                            resp_arg       <= w_rx_bits[39:8];
                            r_cnt          <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end
                    end
                end
                NCC: begin
                    if (w_rise_tick) begin
                        if (r_cnt == C_NCC_LAST) begin
                            done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdio_host_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdio_host_cmd
// Description : Self-checking bench for sdio_host_cmd with a behavioural
//               SD-card model (frame builder, CRC7 by polynomial division).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdio_host_cmd;

    localparam int CLOCK_DIV = 4;
    localparam int NCR_MAX   = 64;
    localparam int NCC_CLKS  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        resp_expected = 1'b0;
    logic        sd_cmd_in = 1'b1;
`ifdef SDIO_HOST_CMD_R4_EN
    logic        resp_no_crc = 1'b0;
`endif
    logic        busy, done, resp_valid, resp_timeout, resp_crc_error;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        sd_clock, sd_cmd_out, sd_cmd_oe;

    int total = 0;
    int bad   = 0;

    sdio_host_cmd #(
        .CLOCK_DIV (CLOCK_DIV),
        .NCR_MAX   (NCR_MAX),
        .NCC_CLKS  (NCC_CLKS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cmd_index      (cmd_index),
        .cmd_arg        (cmd_arg),
        .resp_expected  (resp_expected),
`ifdef SDIO_HOST_CMD_R4_EN
        .resp_no_crc    (resp_no_crc),
`endif
        .busy           (busy),
        .done           (done),
        .resp_valid     (resp_valid),
        .resp_timeout   (resp_timeout),
        .resp_crc_error (resp_crc_error),
        .resp_index     (resp_index),
        .resp_arg       (resp_arg),
        .sd_clock       (sd_clock),
        .sd_cmd_out     (sd_cmd_out),
        .sd_cmd_oe      (sd_cmd_oe),
        .sd_cmd_in      (sd_cmd_in)
    );

    always #5 clock = ~clock;

    // Hang guard in case sd_clock or the FSM stalls
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of (data * x^7) divided by x^7 + x^3 + 1
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] m;
        m = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        end
        return m[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        d = {2'b01, idx, arg};
        return {d, crc7_ref(d), 1'b1};
    endfunction

    function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        d = {2'b00, idx, arg};
        return {d, crc7_ref(d), 1'b1};
    endfunction

    function automatic logic resp_ok(input logic [47:0] r, input logic no_crc);
        return (r[46] == 1'b0) && (r[0] == 1'b1) && (no_crc || r[7:1] == crc7_ref(r[47:8]));
    endfunction

    // One full transaction: issue, capture frame, optionally answer, check outcome.
    // drive_resp=0 with rexp=1 leaves the line idle to provoke a timeout.
    task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic rexp, input logic no_crc, input logic [47:0] exp_frame,
                           input logic drive_resp, input logic [47:0] resp, input int delay,
                           input logic poke_busy);
        logic [47:0] cap;
        logic        seen;
        logic        ev, et, ec;
        @(negedge clock);
        cmd_index     = idx;
        cmd_arg       = arg;
        resp_expected = rexp;
`ifdef SDIO_HOST_CMD_R4_EN
        resp_no_crc   = no_crc;
`endif
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, ":busy_after_start"}, {busy, resp_valid, resp_timeout, resp_crc_error}, 4'b1000);

        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(posedge sd_clock); #1;
            if (sd_cmd_oe) seen = 1'b1;
        end
        check({tag, ":first_bit_seen"}, seen, 1'b1);
        cap = {47'b0, sd_cmd_out};
        for (int b = 1; b < 48; b++) begin
            @(posedge sd_clock); #1;
            cap = {cap[46:0], sd_cmd_out};
            if (poke_busy && b == 10) begin
                @(negedge clock);
                cmd_index = ~idx;
                cmd_arg   = ~arg;
                start     = 1'b1;
                @(negedge clock);
                start     = 1'b0;
            end
        end
        check({tag, ":frame"}, cap, exp_frame);

        @(negedge sd_clock); #1;
        check({tag, ":release"}, {sd_cmd_oe, sd_cmd_out}, 2'b01);

        if (rexp && drive_resp) begin
            for (int d = 1; d < delay; d++) begin
                @(negedge sd_clock); #1;
            end
            for (int b = 47; b >= 0; b--) begin
                sd_cmd_in = resp[b];
                @(negedge sd_clock); #1;
            end
            sd_cmd_in = 1'b1;
        end else if (rexp) begin
            for (int r = 1; r < NCR_MAX; r++) @(posedge sd_clock);
            #1;
            check({tag, ":timeout_early"}, resp_timeout, 1'b0);
            @(posedge sd_clock); #1;
            check({tag, ":timeout_at_ncr_max"}, resp_timeout, 1'b1);
        end

        for (int r = 1; r < NCC_CLKS; r++) @(posedge sd_clock);
        #1;
        check({tag, ":done_early"}, done, 1'b0);
        @(posedge sd_clock); #1;
        check({tag, ":done_pulse"}, {done, busy}, 2'b10);
        @(posedge clock); #1;
        check({tag, ":done_width"}, done, 1'b0);

        ev = 1'b0; et = 1'b0; ec = 1'b0;
        if (rexp) begin
            if (!drive_resp)               et = 1'b1;
            else if (resp_ok(resp, no_crc)) ev = 1'b1;
            else                           ec = 1'b1;
        end
        check({tag, ":flags"}, {resp_valid, resp_timeout, resp_crc_error}, {ev, et, ec});
        if (rexp && drive_resp) begin
            check({tag, ":resp_fields"}, {resp_index, resp_arg}, {resp[45:40], resp[39:8]});
        end
    endtask

    initial begin
        logic [47:0] r;
        logic [31:0] a;
        logic [5:0]  ix;
        int          nb;
        logic        any_done;
        logic        rx;
        logic        dr;

        repeat (3) @(posedge clock);
        #1;
        check("reset_state",
              {busy, done, resp_valid, resp_timeout, resp_crc_error, sd_clock, sd_cmd_out, sd_cmd_oe},
              8'b0000_0010);
        check("reset_resp_fields", {resp_index, resp_arg}, 38'd0);
        @(negedge clock);
        reset = 1'b0;

        // CMD0, no response, with an ignored start pulse mid-frame
        run_txn("cmd0", 6'd0, 32'h0, 1'b0, 1'b0, 48'h400000000095, 1'b0, 48'h0, 1, 1'b1);

        // CMD8 with a valid R7 after 5 sd clocks
        run_txn("cmd8", 6'd8, 32'h000001AA, 1'b1, 1'b0, 48'h48000001AA87,
                1'b1, resp_frame(6'd8, 32'h000001AA), 5, 1'b0);
        check("cmd8_r7_values", {resp_valid, resp_index, resp_arg}, {1'b1, 6'd8, 32'h000001AA});

        // CMD55 with no answer: timeout
        run_txn("cmd55", 6'd55, 32'h0, 1'b1, 1'b0, 48'h770000000065, 1'b0, 48'h0, 1, 1'b0);

        // R1 with one argument bit flipped
        r = resp_frame(6'd13, 32'h00000900);
        r[20] = ~r[20];
        run_txn("r1_argflip", 6'd13, 32'h12340000, 1'b1, 1'b0, cmd_frame(6'd13, 32'h12340000),
                1'b1, r, 3, 1'b0);

        // R1 with the end bit forced low
        r = resp_frame(6'd13, 32'h00000900);
        r[0] = 1'b0;
        run_txn("r1_endbit", 6'd13, 32'h12340000, 1'b1, 1'b0, cmd_frame(6'd13, 32'h12340000),
                1'b1, r, 2, 1'b0);

        // Reset in the middle of SEND
        @(negedge clock);
        cmd_index     = 6'd17;
        cmd_arg       = $urandom;
        resp_expected = 1'b1;
        start         = 1'b1;
        @(negedge clock);
        start = 1'b0;
        nb = 0;
        for (int k = 0; k < 60 && nb < 21; k++) begin
            @(posedge sd_clock); #1;
            if (sd_cmd_oe) nb++;
        end
        #3;
        reset = 1'b1;
        #1;
        check("midreset_release", {sd_cmd_oe, busy, sd_cmd_out, sd_clock}, 4'b0010);
        any_done = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) any_done = 1'b1;
        end
        check("midreset_no_done", any_done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        run_txn("after_reset", 6'd0, 32'h0, 1'b0, 1'b0, 48'h400000000095, 1'b0, 48'h0, 1, 1'b0);

        // Randomised transactions against the card model
        for (int t = 0; t < 12; t++) begin
            ix = 6'($urandom);
            a  = $urandom;
            rx = 1'($urandom);
            dr = ($urandom_range(0, 3) != 0);
            r  = resp_frame(6'($urandom), $urandom);
            case ($urandom_range(0, 2))
                0:       ;
                1:       r[$urandom_range(0, 46)] ^= 1'b1;
                default: r[$urandom_range(1, 7)] ^= 1'b1;
            endcase
            run_txn($sformatf("rand%0d", t), ix, a, rx, 1'b0, cmd_frame(ix, a),
                    dr, r, $urandom_range(1, 20), 1'b0);
        end

`ifdef SDIO_HOST_CMD_R4_EN
        run_txn("cmd5_r4", 6'd5, 32'h00FF8000, 1'b1, 1'b1, cmd_frame(6'd5, 32'h00FF8000),
                1'b1, 48'h3F90FF8000FF, 4, 1'b0);
        check("cmd5_r4_values", {resp_valid, resp_arg}, {1'b1, 32'h90FF8000});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdio_host_cmd.md
Name: sdio_host_cmd

Overview:
- Host (initiator) side of the SD/SDIO CMD line: serialises 48-bit commands, generates sd_clock and receives 48-bit short responses (R1/R4/R5/R6/R7).
- Instantiated in the bench/FPGA loopback design to drive sdio_slave over sd_clock/sd_cmd, and to feed known traffic into the logic analyzer.
- Sits on the 200 MHz system clock domain. Command parameters come from the UART command path.

Parameters:
- CLOCK_DIV, 100, system clocks per sd_clock half-period (minimum 2); sd_clock = clock/(2*CLOCK_DIV).
- NCR_MAX, 64, maximum sd_clock cycles from the command end bit to the response start bit before timeout.
- NCC_CLKS, 8, idle sd_clock cycles after a transaction before done.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; accepted only when busy=0
- cmd_index  in  6  command index
- cmd_arg  in  32  command argument
- resp_expected  in  1  1 = wait for a 48-bit response
- busy  out  1  transaction in progress
- done  out  1  single-cycle pulse at the end of a transaction
- resp_valid  out  1  response received with no error; held until the next start
- resp_timeout  out  1  no start bit within NCR_MAX; held until the next start
- resp_crc_error  out  1  CRC7, transmission-bit or end-bit error; held until the next start
- resp_index  out  6  received index field
- resp_arg  out  32  received 32-bit field
- sd_clock  out  1  SD clock, free-running
- sd_cmd_out  out  1  CMD drive value
- sd_cmd_oe  out  1  CMD output enable
- sd_cmd_in  in  1  CMD line as sampled from the pad

Behaviour:
- Reset values: busy=0, done=0, all resp_* outputs=0, sd_clock=0, sd_cmd_out=1, sd_cmd_oe=0, state=IDLE. Reset is honoured mid-transaction: the line is released within 0 clocks (async) and no done pulse is produced.
- Clock divider:
  - div_cnt counts 0..CLOCK_DIV-1; sd_clock toggles on wrap.
  - fall_tick is the cycle sd_clock goes 1->0; rise_tick is the cycle it goes 0->1.
- Host changes CMD only on fall_tick and samples sd_cmd_in only on rise_tick.
- Command frame, MSB first:
  - Fields: start 0, transmission 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], end 1.
  - CRC7 polynomial is x^7+x^3+1, initial 0, computed over the first 40 bits.
  - CRC is computed serially while shifting; no precompute is needed.
- start in IDLE latches cmd_index, cmd_arg and resp_expected, clears the resp_* flags, sets busy and enters WAIT_EDGE. A start while busy=1 is ignored.
- States:
  - IDLE.
  - WAIT_EDGE: on the next fall_tick, set oe=1 and drive bit 47 -> SEND.
  - SEND: 48 bits, one per fall_tick. On the fall_tick after the end bit, set oe=0, out=1, and go to NCR if resp_expected, else NCC.
  - NCR: count rise_ticks. Sampling 0 -> RECV with bit 47 taken. After NCR_MAX rise_ticks without a 0 -> set resp_timeout -> NCC.
  - RECV: sample 47 more bits on rise_ticks. After the last bit, check: transmission bit=0, CRC7 of bits 47..8 equals bits 7..1, end bit=1. Set resp_valid or resp_crc_error, load resp_index and resp_arg in both cases -> NCC.
  - NCC: NCC_CLKS rise_ticks with line released -> pulse done, clear busy -> IDLE.
- The cycle-accurate bit period equals one sd_clock period. Latency from start to the first bit on the line is at most 2*CLOCK_DIV+1 clocks.
- resp_valid, resp_timeout and resp_crc_error are mutually exclusive. All three stay 0 when resp_expected=0.

Optional Feature:
- Macro SDIO_HOST_CMD_R4_EN.
- When defined:
  - Extra input port resp_no_crc (1 bit), latched on start.
  - When set, the CRC7 and index checks are skipped (R4 for CMD5 carries 111111/1111111 fields). Only the transmission and end bits are checked.
- When undefined: the port is absent and every response is fully CRC-checked.

Test Plan:
- CMD0, arg 0x00000000, resp_expected=0 -> line carries 0x400000000095; oe low after the end bit; done after 8 sd clocks; no resp_* flag set.
- CMD8, arg 0x000001AA -> line carries 0x48000001AA87; bench model returns a valid R7 (index 8, arg 0x000001AA, model CRC) after 5 sd clocks -> resp_valid=1, resp_index=8, resp_arg=0x000001AA.
- CMD55, arg 0 -> 0x770000000065; no response driven -> resp_timeout=1 exactly after 64 rise_ticks, then done.
- Valid R1 with one arg bit flipped -> resp_crc_error=1, resp_valid=0. End bit forced 0 -> resp_crc_error=1.
- Reset asserted at bit 20 of SEND -> oe=0, busy=0 immediately, no done; a following start sends a full correct frame.
- With SDIO_HOST_CMD_R4_EN, CMD5 with resp_no_crc=1 and response 0x3F_90FF8000_FF -> resp_valid=1, resp_arg=0x90FF8000.
